// File: rtl/cle_sram_arb.sv
// ---------------------------------------------------------------------------
// cle_sram_arb
//
// Arbitrates the single-ported 1024x8 CLE label SRAM between two requesters:
//   requester 0 = label writer, requester 1 = equivalence/merge unit.
// Round-robin grant with an optional lock for read-modify-write sequences.
// A watchdog forcibly releases a lock that sits idle for LOCK_MAX cycles.
// All SRAM-side outputs are registered. Read data returns with a fixed
// latency: rvalidi is high in the cycle after edge N+2 for a read accepted
// at edge N.
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous active-high reset
//   req0/req1         requester wants a transfer this cycle
//   we0/we1           1 = write, 0 = read
//   lock0/lock1       keep the grant after this transfer
//   addr0/addr1       transfer address (AW bits)
//   wdata0/wdata1     write data (DW bits)
//   gnt0/gnt1         combinational grant; accept = reqi & gnti at a rising edge
//   rvalid0/rvalid1   read data valid on rdata this cycle
//   rdata             shared read data, passthrough of sram_q
//   lock_err          one-cycle pulse when the watchdog drops a lock
//   sram_a/sram_d     registered SRAM address / write data
//   sram_wen          registered SRAM write enable, active-low
//   sram_q            SRAM read data
// ---------------------------------------------------------------------------
module cle_sram_arb #(
   parameter int AW       = 10,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          lock_err,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_d,
   output logic          sram_wen,
   input  logic [DW-1:0] sram_q
);

   localparam logic [1:0] ST_OPEN  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;

   // Watchdog fires on the idle cycle that would bring the count to LOCK_MAX.
   localparam logic [7:0] WD_LAST = 8'(LOCK_MAX - 1);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic          prio_r;
   logic          prio_nxt_s;
   logic [7:0]    wd_cnt_r;
   logic [7:0]    wd_cnt_nxt_s;
   logic          wd_fire_s;
   logic          gnt0_s;
   logic          gnt1_s;
   logic          acc0_s;
   logic          acc1_s;
   logic          lock_err_r;
   logic [AW-1:0] sram_a_r;
   logic [DW-1:0] sram_d_r;
   logic          sram_wen_r;
   // [0]: read issued on the SRAM pins, [1]: read sampled by the SRAM
   logic [1:0]    rd0_pipe_r;
   logic [1:0]    rd1_pipe_r;
   logic          rvalid0_r;
   logic          rvalid1_r;

   // Grant decode: round-robin when open, owner-only when locked.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      case (state_r)
         ST_OPEN: begin
            if (req0 && req1) begin
               if (prio_r) begin
                  gnt1_s = 1'b1;
               end else begin
                  gnt0_s = 1'b1;
               end
            end else begin
               gnt0_s = req0;
               gnt1_s = req1;
            end
         end
         ST_LOCK0: gnt0_s = req0;
         ST_LOCK1: gnt1_s = req1;
         default: begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      endcase
   end

   assign acc0_s = req0 & gnt0_s;
   assign acc1_s = req1 & gnt1_s;

   // Next arbiter state, priority pointer and watchdog count.
   // An owner transfer is checked before the watchdog, so it wins a tie.
   always_comb begin
      state_nxt_s  = state_r;
      prio_nxt_s   = prio_r;
      wd_cnt_nxt_s = wd_cnt_r;
      wd_fire_s    = 1'b0;
      if (acc0_s) begin
         wd_cnt_nxt_s = 8'd0;
         if (lock0) begin
            state_nxt_s = ST_LOCK0;
         end else begin
            state_nxt_s = ST_OPEN;
            prio_nxt_s  = 1'b1;
         end
      end else if (acc1_s) begin
         wd_cnt_nxt_s = 8'd0;
         if (lock1) begin
            state_nxt_s = ST_LOCK1;
         end else begin
            state_nxt_s = ST_OPEN;
            prio_nxt_s  = 1'b0;
         end
      end else if ((state_r == ST_LOCK0) || (state_r == ST_LOCK1)) begin
         if (wd_cnt_r == WD_LAST) begin
            wd_fire_s    = 1'b1;
            wd_cnt_nxt_s = 8'd0;
            state_nxt_s  = ST_OPEN;
            prio_nxt_s   = (state_r == ST_LOCK0) ? 1'b1 : 1'b0;
         end else begin
            wd_cnt_nxt_s = wd_cnt_r + 8'd1;
         end
      end else begin
         wd_cnt_nxt_s = 8'd0;
      end
   end

   // Arbiter state registers and watchdog pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_OPEN;
         prio_r     <= 1'b0;
         wd_cnt_r   <= 8'd0;
         lock_err_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         prio_r     <= prio_nxt_s;
         wd_cnt_r   <= wd_cnt_nxt_s;
         lock_err_r <= wd_fire_s;
      end
   end

   // SRAM pin registers: load from the winner, otherwise idle the write enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_a_r   <= '0;
         sram_d_r   <= '0;
         sram_wen_r <= 1'b1;
      end else if (acc0_s) begin
         sram_a_r   <= addr0;
         sram_d_r   <= wdata0;
         sram_wen_r <= ~we0;
      end else if (acc1_s) begin
         sram_a_r   <= addr1;
         sram_d_r   <= wdata1;
         sram_wen_r <= ~we1;
      end else begin
         sram_wen_r <= 1'b1;
      end
   end

   // Read-return tracking: issue flag follows the SRAM pins, then two stages
   // to line up with the SRAM output; reset drops any reads in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd0_pipe_r <= 2'b00;
         rd1_pipe_r <= 2'b00;
         rvalid0_r  <= 1'b0;
         rvalid1_r  <= 1'b0;
      end else begin
         rd0_pipe_r <= {rd0_pipe_r[0], acc0_s & ~we0};
         rd1_pipe_r <= {rd1_pipe_r[0], acc1_s & ~we1};
         rvalid0_r  <= rd0_pipe_r[1];
         rvalid1_r  <= rd1_pipe_r[1];
      end
   end

   assign gnt0     = gnt0_s;
   assign gnt1     = gnt1_s;
   assign rvalid0  = rvalid0_r;
   assign rvalid1  = rvalid1_r;
   assign rdata    = sram_q;
   assign lock_err = lock_err_r;
   assign sram_a   = sram_a_r;
   assign sram_d   = sram_d_r;
   assign sram_wen = sram_wen_r;

endmodule

// File: tb/tb_cle_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_cle_sram_arb
//
// Directed bench for cle_sram_arb with LOCK_MAX = 4. A behavioural label SRAM
// model (write at the sampling edge, data out one edge later) sits on the
// SRAM pins so that read data lines up with rvalid two cycles after accept.
// Inputs are driven 2 time units after each rising edge; combinational
// grants are sampled 1 unit after that, registered outputs right after the
// edge settle.
// ---------------------------------------------------------------------------
module tb_cle_sram_arb;

   logic       clk;
   logic       reset;
   logic       req0, req1, we0, we1, lock0, lock1;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, lock_err, sram_wen;
   logic [7:0] rdata, sram_d, sram_q;
   logic [9:0] sram_a;

   logic [7:0] mem [0:1023];
   logic [7:0] q_pipe;

   int n_chk;
   int n_pass;
   int pulses;
   int rv0_cnt;
   int rv1_cnt;

   cle_sram_arb #(.AW(10), .DW(8), .LOCK_MAX(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .lock0    (lock0),
      .lock1    (lock1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1),
      .rdata    (rdata),
      .lock_err (lock_err),
      .sram_a   (sram_a),
      .sram_d   (sram_d),
      .sram_wen (sram_wen),
      .sram_q   (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Label SRAM model: registered output stage after the array read.
   always @(posedge clk) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      q_pipe <= mem[sram_a];
      sram_q <= q_pipe;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; pulses = 0; rv0_cnt = 0; rv1_cnt = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      q_pipe = 8'h00; sram_q = 8'h00;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      lock0 = 1'b0; lock1 = 1'b0;
      addr0 = 10'h000; addr1 = 10'h000; wdata0 = 8'h00; wdata1 = 8'h00;

      // ---------------- reset values ----------------
      #1;
      check("rst_wen",    32'(sram_wen), 32'd1);
      check("rst_a",      32'(sram_a),   32'd0);
      check("rst_d",      32'(sram_d),   32'd0);
      check("rst_rv0",    32'(rvalid0),  32'd0);
      check("rst_rv1",    32'(rvalid1),  32'd0);
      check("rst_lerr",   32'(lock_err), 32'd0);
      req0 = 1'b1;
      #1;
      check("rst_gnt0",   32'(gnt0), 32'd1);
      check("rst_gnt1",   32'(gnt1), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req0  = 1'b0;
      tick();

      // ---------------- write then read 0x3FF ----------------
      req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3FF; wdata0 = 8'hA5;
      #1; check("wr_gnt0", 32'(gnt0), 32'd1);
      tick();
      check("wr_wen",  32'(sram_wen), 32'd0);
      check("wr_a",    32'(sram_a),   32'h3FF);
      check("wr_d",    32'(sram_d),   32'hA5);
      we0 = 1'b0;
      #1; check("rd_gnt0", 32'(gnt0), 32'd1);
      tick();
      check("rd_wen", 32'(sram_wen), 32'd1);
      req0 = 1'b0;
      tick();
      check("rd_rv0_early", 32'(rvalid0), 32'd0);
      tick();
      check("rd_rv0",   32'(rvalid0), 32'd1);
      check("rd_data",  32'(rdata),   32'hA5);
      check("rd_rv1",   32'(rvalid1), 32'd0);
      tick();
      check("rd_rv0_end", 32'(rvalid0), 32'd0);

      // requester 1 writes 0x3C at 0x010 (also hands priority back to 0)
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'h010; wdata1 = 8'h3C;
      #1; check("w1_gnt1", 32'(gnt1), 32'd1);
      tick();
      req1 = 1'b0; we1 = 1'b0;
      tick();

      // ---------------- fairness: 6 cycles, both requesting reads ----------------
      addr0 = 10'h3FF; addr1 = 10'h010;
      for (int j = 0; j < 9; j++) begin
         if (j < 6) begin
            req0 = 1'b1; req1 = 1'b1;
            #1;
            check("fair_gnt0", 32'(gnt0), 32'((j % 2) == 0));
            check("fair_gnt1", 32'(gnt1), 32'((j % 2) == 1));
         end else begin
            req0 = 1'b0; req1 = 1'b0;
         end
         tick();
         check("fair_rv0", 32'(rvalid0), 32'((j == 2) || (j == 4) || (j == 6)));
         check("fair_rv1", 32'(rvalid1), 32'((j == 3) || (j == 5) || (j == 7)));
         if (rvalid0) begin
            rv0_cnt = rv0_cnt + 1;
            check("fair_d0", 32'(rdata), 32'hA5);
         end
         if (rvalid1) begin
            rv1_cnt = rv1_cnt + 1;
            check("fair_d1", 32'(rdata), 32'h3C);
         end
      end
      check("fair_n0", 32'(rv0_cnt), 32'd3);
      check("fair_n1", 32'(rv1_cnt), 32'd3);

      // ---------------- locked read-modify-write by requester 1 ----------------
      req0 = 1'b1; addr0 = 10'h000;      // one req0 read: priority moves to 1
      tick();
      lock1 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h010;
      #1;
      check("rmw_rd_gnt1", 32'(gnt1), 32'd1);
      check("rmw_rd_gnt0", 32'(gnt0), 32'd0);
      tick();
      req1 = 1'b0;
      #1; check("rmw_idle_gnt0", 32'(gnt0), 32'd0);
      tick();
      req1 = 1'b1; we1 = 1'b1; lock1 = 1'b0; wdata1 = 8'h3D;
      #1;
      check("rmw_wr_gnt1", 32'(gnt1), 32'd1);
      check("rmw_wr_gnt0", 32'(gnt0), 32'd0);
      tick();
      check("rmw_wr_wen", 32'(sram_wen), 32'd0);
      check("rmw_wr_d",   32'(sram_d),   32'h3D);
      req1 = 1'b0; we1 = 1'b0;
      #1; check("rmw_after_gnt0", 32'(gnt0), 32'd1);
      tick();

      // ---------------- watchdog (LOCK_MAX = 4) ----------------
      req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 10'h010;
      #1;
      check("wd_gnt1", 32'(gnt1), 32'd1);
      tick();
      req1 = 1'b0; lock1 = 1'b0;
      for (int m = 0; m < 6; m++) begin
         #1;
         check("wd_lerr", 32'(lock_err), 32'(m == 4));
         check("wd_gnt0", 32'(gnt0),     32'(m >= 4));
         if (lock_err) pulses = pulses + 1;
         tick();
      end
      check("wd_pulses", 32'(pulses), 32'd1);
      req0 = 1'b0;
      tick();

      // ---------------- reset during a read ----------------
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
      tick();
      req0 = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_wen",  32'(sram_wen), 32'd1);
      check("mid_rst_a",    32'(sram_a),   32'd0);
      check("mid_rst_d",    32'(sram_d),   32'd0);
      check("mid_rst_rv0",  32'(rvalid0),  32'd0);
      check("mid_rst_lerr", 32'(lock_err), 32'd0);
      req0 = 1'b1;
      #1;
      check("mid_rst_gnt0", 32'(gnt0), 32'd1);
      check("mid_rst_gnt1", 32'(gnt1), 32'd0);
      tick();
      check("mid_rst_rv0_hold", 32'(rvalid0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req0  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_no_rv0", 32'(rvalid0), 32'd0);
      end
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
      tick();
      req0 = 1'b0;
      tick();
      check("post_rst_rv0_early", 32'(rvalid0), 32'd0);
      tick();
      check("post_rst_rv0",  32'(rvalid0), 32'd1);
      check("post_rst_data", 32'(rdata),   32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cle_sram_arb.md
# cle_sram_arb

Two-port arbiter for the single-ported 1024x8 synchronous label SRAM used by the component labeling engine (CLE). It lets two internal requesters share the SRAM: requester 0 is the label writer, requester 1 is the equivalence/merge unit. Arbitration is round-robin with an optional lock for read-modify-write sequences and a lock watchdog. All SRAM-side signals are registered, and read data is returned with a fixed latency.

## Interface

Parameters:
- AW, 10: SRAM address width.
- DW, 8: SRAM data width.
- LOCK_MAX, 16: cycles a lock may sit without an owner transfer before it is forcibly released; legal range 2..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  requester i wants a transfer this cycle.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  keep the grant after this transfer.
- addr0 / addr1  in  AW  transfer address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational grant; a transfer is accepted at a rising edge where reqi & gnti = 1.
- rvalid0 / rvalid1  out  1  read data valid on rdata this cycle.
- rdata  out  DW  sram_q passthrough, shared by both requesters.
- lock_err  out  1  one-cycle pulse when the watchdog releases a lock.
- sram_a  out  AW  registered SRAM address.
- sram_d  out  DW  registered SRAM write data.
- sram_wen  out  1  registered write enable, active-low.
- sram_q  in  DW  SRAM read data, valid after the edge that samples a read.

## Operation

- Arbiter states:
  - OPEN: grant follows round-robin priority pointer `prio` (0 or 1).
  - LOCK0 / LOCK1: only the owner may be granted.
- Grant in OPEN: if only one requester requests, it is granted. If both request, requester `prio` is granted. At most one gnt is high in any cycle.
- Grant in LOCKi: gnti = reqi; the other gnt is 0.
- Accepted transfer by i with locki = 0:
  - State goes to OPEN.
  - `prio` becomes 1-i.
- Accepted transfer by i with locki = 1: state goes to LOCKi; `prio` is unchanged.
- No accepted transfer: state and `prio` hold, except for the watchdog below.
- Watchdog:
  - In LOCKi, a counter increments every cycle without an accepted transfer from owner i.
  - The counter clears on each accepted owner transfer and on entry to LOCKi.
  - When the counter reaches LOCK_MAX: state goes to OPEN, `prio` becomes 1-i, lock_err pulses for one cycle, and the counter clears.
- SRAM issue:
  - At the accepting edge, sram_a, sram_d and sram_wen are loaded from the winner (sram_wen = ~we).
  - In a cycle with no accepted transfer, sram_wen loads 1, and sram_a / sram_d hold their values.
- Read return: a per-requester 2-deep shift of "read issued" flags drives rvalidi exactly 2 cycles after the accepting edge. rdata = sram_q combinationally.
- Back-to-back accepted transfers, one per cycle, are legal from either requester and in any mix. The SRAM sees one access per cycle, in acceptance order.
- Read-after-write to the same address on consecutive accepts returns the new data, because the SRAM processes accesses in order.

## Timing

- Reset values (asynchronous): sram_wen=1, sram_a=0, sram_d=0, rvalid0=rvalid1=0, lock_err=0, state=OPEN, prio=0, watchdog=0.
- Gnt after reset follows the OPEN rules, combinationally from req.
- Read latency:
  - Transfer accepted at edge N.
  - SRAM samples the access at edge N+1.
  - rvalidi is high and rdata valid in the cycle after edge N+2, i.e. 2 cycles after acceptance.
- Write latency: the SRAM is written at edge N+1.
- Reset asserted mid-operation: pending rvalid flags are cleared and the lock is dropped. No rvalid appears for reads accepted before reset.
- Simultaneous watchdog expiry and an owner request in the same cycle: the owner transfer wins, and the watchdog does not fire.
- A requester may change req, addr or we in any cycle; only values at accepting edges matter.

## Test plan

- Reset: assert reset mid-cycle -> all outputs take their reset values immediately; gnt0=1 with only req0=1.
- Write/read: req0 write addr 0x3FF data 0xA5, then req0 read 0x3FF on the next cycle -> sram_wen=0 for one cycle; rvalid0 high 2 cycles after the read accept; rdata=0xA5; rvalid1 stays 0.
- Fairness: req0 and req1 both held high for 6 cycles of reads -> grants alternate 0,1,0,1,0,1; each gets 3 rvalids, each 2 cycles after its accept.
- Locked RMW: req1 read addr 0x010 with lock1=1, then one idle cycle, then req1 write 0x010 with lock1=0, with req0 high throughout -> gnt0=0 until the write is accepted; gnt0=1 the following cycle.
- Watchdog with LOCK_MAX=4: req1 locked read, then req1 low, req0 high -> lock_err pulses exactly once, 4 cycles after entering LOCK1; gnt0=1 the next cycle.
- Reset during a read: reset asserted 1 cycle after a req0 read accept -> rvalid0 never asserts; after reset, a new read of a written address returns the correct data.
